// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction sequencer: state encoding,
// note amount codes, mechanism direction and amount-to-units mapping.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIN    = 3'd1,
    ST_MENU   = 3'd2,
    ST_AMOUNT = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5,
    ST_LOCK   = 3'd6
  } state_e;

  localparam logic [1:0] AMT_INVALID = 2'b00;
  localparam logic [1:0] FIFTY       = 2'b01;
  localparam logic [1:0] HUNDRED     = 2'b10;
  localparam logic [1:0] TWO_HUNDRED = 2'b11;

  localparam logic DIR_ACCEPT   = 1'b0;
  localparam logic DIR_DISPENSE = 1'b1;

  // Amount code to note units (1 unit = 50000); the invalid code maps to 0.
  function automatic logic [2:0] amt_units(input logic [1:0] code);
    logic [2:0] u;
    case (code)
      FIFTY:       u = 3'd1;
      HUNDRED:     u = 3'd2;
      TWO_HUNDRED: u = 3'd4;
      default:     u = 3'd0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// Idle-cycle counter for the interactive states. Counts while run is high,
// saturates at TIMEOUT and flags expired there; clear wins over run.
module atm_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear first, otherwise step up until the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM transaction sequencer: card session, PIN retry/lockout, menu, amount
// check, dispenser req/ack handshake and the account balance register.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int BAL_W     = 16,
  parameter int INIT_BAL  = 20,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             choice_valid,
  input  logic             choice,
  input  logic             amount_valid,
  input  logic [1:0]       amount,
  input  logic             disp_ack,
  output logic             disp_req,
  output logic             disp_dir,
  output logic [1:0]       disp_amt,
  output logic [BAL_W-1:0] balance,
  output logic             card_eject,
  output logic             card_retain,
  output logic             txn_done,
  output logic             txn_err,
  output logic [2:0]       state_o
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             choice_q, choice_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             disp_req_q, disp_req_d;
  logic             disp_dir_q, disp_dir_d;
  logic [1:0]       disp_amt_q, disp_amt_d;
  logic             card_eject_q, card_eject_d;
  logic             card_retain_q, card_retain_d;
  logic             txn_done_q, txn_done_d;
  logic             txn_err_q, txn_err_d;

  logic             tmo_accept;
  logic             tmo_run;
  logic             tmo_clear;
  logic             tmo_expired;

  logic [TW-1:0]    tries_inc;
  logic [BAL_W:0]   units_in_ext;
  logic [BAL_W:0]   units_q_ext;
  logic [BAL_W:0]   dep_sum;
  logic             short_funds;

  assign tries_inc    = tries_q + 1'b1;
  assign units_in_ext = (BAL_W + 1)'(amt_units(amount));
  // During EXEC the latched mechanism amount is the transaction amount.
  assign units_q_ext  = (BAL_W + 1)'(amt_units(disp_amt_q));
  assign dep_sum      = {1'b0, balance_q} + units_q_ext;
  assign short_funds  = (choice_q == DIR_DISPENSE) && (units_in_ext > {1'b0, balance_q});

  // Idle timer runs only while waiting on the customer; any accepted strobe
  // or state change restarts it.
  assign tmo_run   = (state_q == ST_PIN) || (state_q == ST_MENU) || (state_q == ST_AMOUNT);
  assign tmo_clear = tmo_accept || (state_d != state_q);

  atm_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .run     (tmo_run),
    .clear   (tmo_clear),
    .expired (tmo_expired)
  );

  // Next-state and registered-output decode; pulses default low each cycle.
  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    choice_d      = choice_q;
    balance_d     = balance_q;
    disp_req_d    = disp_req_q;
    disp_dir_d    = disp_dir_q;
    disp_amt_d    = disp_amt_q;
    card_retain_d = card_retain_q;
    card_eject_d  = 1'b0;
    txn_done_d    = 1'b0;
    txn_err_d     = 1'b0;
    tmo_accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (card_in) begin
          state_d = ST_PIN;
          tries_d = '0;
        end
      end

      ST_PIN: begin
        if (!card_in) begin
          state_d   = ST_IDLE;
          txn_err_d = 1'b1;
        end else if (pin_valid) begin
          tmo_accept = 1'b1;
          if (pin_ok) begin
            state_d = ST_MENU;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TW'(MAX_TRIES)) begin
              state_d       = ST_LOCK;
              card_retain_d = 1'b1;
              txn_err_d     = 1'b1;
            end
          end
        end else if (tmo_expired) begin
          state_d      = ST_DONE;
          txn_err_d    = 1'b1;
          card_eject_d = 1'b1;
        end
      end

      ST_MENU: begin
        if (!card_in) begin
          state_d   = ST_IDLE;
          txn_err_d = 1'b1;
        end else if (choice_valid) begin
          tmo_accept = 1'b1;
          choice_d   = choice;
          state_d    = ST_AMOUNT;
        end else if (tmo_expired) begin
          state_d      = ST_DONE;
          txn_err_d    = 1'b1;
          card_eject_d = 1'b1;
        end
      end

      ST_AMOUNT: begin
        if (!card_in) begin
          state_d   = ST_IDLE;
          txn_err_d = 1'b1;
        end else if (amount_valid && (amount != AMT_INVALID)) begin
          tmo_accept = 1'b1;
          if (short_funds) begin
            state_d      = ST_DONE;
            txn_err_d    = 1'b1;
            card_eject_d = 1'b1;
          end else begin
            state_d    = ST_EXEC;
            disp_req_d = 1'b1;
            disp_dir_d = choice_q;
            disp_amt_d = amount;
          end
        end else if (tmo_expired) begin
          state_d      = ST_DONE;
          txn_err_d    = 1'b1;
          card_eject_d = 1'b1;
        end
      end

      ST_EXEC: begin
        // Mechanism transfer always runs to completion.
        if (disp_ack) begin
          disp_req_d   = 1'b0;
          txn_done_d   = 1'b1;
          card_eject_d = 1'b1;
          state_d      = ST_DONE;
          if (disp_dir_q == DIR_DISPENSE) begin
            balance_d = balance_q - units_q_ext[BAL_W-1:0];
          end else if (dep_sum[BAL_W]) begin
            balance_d = '1;
          end else begin
            balance_d = dep_sum[BAL_W-1:0];
          end
        end
      end

      ST_DONE: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCK: begin
        state_d = ST_LOCK;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tries_q       <= '0;
      choice_q      <= 1'b0;
      balance_q     <= BAL_W'(INIT_BAL);
      disp_req_q    <= 1'b0;
      disp_dir_q    <= 1'b0;
      disp_amt_q    <= 2'b00;
      card_eject_q  <= 1'b0;
      card_retain_q <= 1'b0;
      txn_done_q    <= 1'b0;
      txn_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tries_q       <= tries_d;
      choice_q      <= choice_d;
      balance_q     <= balance_d;
      disp_req_q    <= disp_req_d;
      disp_dir_q    <= disp_dir_d;
      disp_amt_q    <= disp_amt_d;
      card_eject_q  <= card_eject_d;
      card_retain_q <= card_retain_d;
      txn_done_q    <= txn_done_d;
      txn_err_q     <= txn_err_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_dir    = disp_dir_q;
  assign disp_amt    = disp_amt_q;
  assign balance     = balance_q;
  assign card_eject  = card_eject_q;
  assign card_retain = card_retain_q;
  assign txn_done    = txn_done_q;
  assign txn_err     = txn_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Bench for atm_txn_ctrl. Three instances share the keypad strobes but have
// their own card_in: a default one (scoreboarded txn_done/txn_err events),
// a low-balance one and a narrow-balance one for saturation.
module tb_atm_txn_ctrl;

  localparam int TMO = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic card_in_a = 1'b0, card_in_b = 1'b0, card_in_c = 1'b0;
  logic pin_valid = 1'b0, pin_ok = 1'b0;
  logic choice_valid = 1'b0, choice = 1'b0;
  logic amount_valid = 1'b0;
  logic [1:0] amount = 2'b00;
  logic disp_ack = 1'b0;

  logic a_req, a_dir, a_eject, a_retain, a_done, a_err;
  logic [1:0] a_amt;
  logic [15:0] a_bal;
  logic [2:0] a_state;
  logic b_req, b_dir, b_eject, b_retain, b_done, b_err;
  logic [1:0] b_amt;
  logic [15:0] b_bal;
  logic [2:0] b_state;
  logic c_req, c_dir, c_eject, c_retain, c_done, c_err;
  logic [1:0] c_amt;
  logic [3:0] c_bal;
  logic [2:0] c_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        is_err;
    logic [15:0] bal;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  atm_txn_ctrl #(.BAL_W(16), .INIT_BAL(20), .MAX_TRIES(3), .TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(reset), .card_in(card_in_a),
    .pin_valid(pin_valid), .pin_ok(pin_ok),
    .choice_valid(choice_valid), .choice(choice),
    .amount_valid(amount_valid), .amount(amount), .disp_ack(disp_ack),
    .disp_req(a_req), .disp_dir(a_dir), .disp_amt(a_amt), .balance(a_bal),
    .card_eject(a_eject), .card_retain(a_retain), .txn_done(a_done),
    .txn_err(a_err), .state_o(a_state)
  );

  atm_txn_ctrl #(.BAL_W(16), .INIT_BAL(3), .MAX_TRIES(3), .TIMEOUT(TMO)) u_lo (
    .clock(clock), .reset(reset), .card_in(card_in_b),
    .pin_valid(pin_valid), .pin_ok(pin_ok),
    .choice_valid(choice_valid), .choice(choice),
    .amount_valid(amount_valid), .amount(amount), .disp_ack(disp_ack),
    .disp_req(b_req), .disp_dir(b_dir), .disp_amt(b_amt), .balance(b_bal),
    .card_eject(b_eject), .card_retain(b_retain), .txn_done(b_done),
    .txn_err(b_err), .state_o(b_state)
  );

  atm_txn_ctrl #(.BAL_W(4), .INIT_BAL(14), .MAX_TRIES(3), .TIMEOUT(TMO)) u_sat (
    .clock(clock), .reset(reset), .card_in(card_in_c),
    .pin_valid(pin_valid), .pin_ok(pin_ok),
    .choice_valid(choice_valid), .choice(choice),
    .amount_valid(amount_valid), .amount(amount), .disp_ack(disp_ack),
    .disp_req(c_req), .disp_dir(c_dir), .disp_amt(c_amt), .balance(c_bal),
    .card_eject(c_eject), .card_retain(c_retain), .txn_done(c_done),
    .txn_err(c_err), .state_o(c_state)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push(input logic is_err, input logic [15:0] bal);
    exp_t e;
    e.is_err = is_err;
    e.bal    = bal;
    sb_q.push_back(e);
  endtask

  task automatic pin(input logic ok);
    pin_valid = 1'b1;
    pin_ok    = ok;
    tick();
    pin_valid = 1'b0;
    pin_ok    = 1'b0;
  endtask

  task automatic sel(input logic c);
    choice_valid = 1'b1;
    choice       = c;
    tick();
    choice_valid = 1'b0;
    choice       = 1'b0;
  endtask

  task automatic amt(input logic [1:0] a);
    amount_valid = 1'b1;
    amount       = a;
    tick();
    amount_valid = 1'b0;
    amount       = 2'b00;
  endtask

  // Scoreboard side: every completion/refusal pulse of the default instance
  // is matched against the next expected event.
  always @(negedge clock) begin
    if (!reset && (a_done || a_err)) begin
      exp_t e;
      chk_eq("sb_pending", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_eq("sb_kind", {30'd0, a_err, a_done}, e.is_err ? 32'd2 : 32'd1);
        chk_eq("sb_balance", a_bal, e.bal);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    // Reset state
    tick(); tick(); tick();
    chk_eq("rst_state", a_state, 0);
    chk_eq("rst_balance", a_bal, 20);
    chk_eq("rst_req", a_req, 0);
    chk_eq("rst_retain", a_retain, 0);
    chk_eq("rst_eject", a_eject, 0);
    chk_eq("rst_bal_lo", b_bal, 3);
    chk_eq("rst_bal_sat", c_bal, 14);
    reset = 1'b0;
    tick();

    // Withdraw 2 units, ack on the third request cycle
    card_in_a = 1'b1; tick();
    chk_eq("t1_pin_state", a_state, 1);
    pin(1'b1);
    chk_eq("t1_menu_state", a_state, 2);
    sel(1'b1);
    push(1'b0, 16'd18);
    amt(2'b10);
    chk_eq("t1_req_c1", a_req, 1);
    chk_eq("t1_dir", a_dir, 1);
    chk_eq("t1_amt", a_amt, 2'b10);
    tick();
    chk_eq("t1_req_c2", a_req, 1);
    chk_eq("t1_amt_c2", a_amt, 2'b10);
    chk_eq("t1_bal_hold", a_bal, 20);
    tick();
    chk_eq("t1_req_c3", a_req, 1);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk_eq("t1_req_drop", a_req, 0);
    chk_eq("t1_done", a_done, 1);
    chk_eq("t1_eject", a_eject, 1);
    chk_eq("t1_balance", a_bal, 18);
    chk_eq("t1_state_done", a_state, 5);
    tick();
    chk_eq("t1_done_pulse", a_done, 0);
    chk_eq("t1_eject_pulse", a_eject, 0);
    chk_eq("t1_wait_card", a_state, 5);
    card_in_a = 1'b0; tick();
    chk_eq("t1_idle", a_state, 0);

    // Three wrong PINs lock the card
    card_in_a = 1'b1; tick();
    pin(1'b0);
    chk_eq("t2_try1", a_state, 1);
    pin(1'b0);
    chk_eq("t2_try2", a_state, 1);
    push(1'b1, 16'd18);
    pin(1'b0);
    chk_eq("t2_lock", a_state, 6);
    chk_eq("t2_retain", a_retain, 1);
    chk_eq("t2_err", a_err, 1);
    tick();
    chk_eq("t2_err_pulse", a_err, 0);
    for (int i = 0; i < 4; i++) begin
      card_in_a = ~card_in_a; tick();
      chk_eq("t2_retain_hold", a_retain, 1);
      chk_eq("t2_lock_hold", a_state, 6);
    end

    // Withdraw 4 units against a balance of 3
    card_in_b = 1'b1; tick();
    pin(1'b1);
    sel(1'b1);
    amt(2'b11);
    chk_eq("t3_state", b_state, 5);
    chk_eq("t3_err", b_err, 1);
    chk_eq("t3_eject", b_eject, 1);
    chk_eq("t3_no_req", b_req, 0);
    chk_eq("t3_balance", b_bal, 3);
    tick();
    chk_eq("t3_no_req2", b_req, 0);
    chk_eq("t3_eject_pulse", b_eject, 0);
    card_in_b = 1'b0; tick();
    chk_eq("t3_idle", b_state, 0);

    // Deposit 4 units into 14 with a 4-bit balance
    card_in_c = 1'b1; tick();
    pin(1'b1);
    sel(1'b0);
    amt(2'b11);
    chk_eq("t4_req", c_req, 1);
    chk_eq("t4_dir", c_dir, 0);
    chk_eq("t4_amt", c_amt, 2'b11);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk_eq("t4_req_drop", c_req, 0);
    chk_eq("t4_sat", c_bal, 15);
    chk_eq("t4_done", c_done, 1);
    card_in_c = 1'b0; tick();

    // Reset everything out of LOCK
    reset = 1'b1; card_in_a = 1'b0; tick(); tick();
    reset = 1'b0;
    chk_eq("r2_state", a_state, 0);
    chk_eq("r2_retain", a_retain, 0);
    chk_eq("r2_balance", a_bal, 20);

    // MENU timeout
    card_in_a = 1'b1; tick();
    pin(1'b1);
    chk_eq("t5_menu", a_state, 2);
    push(1'b1, 16'd20);
    waited = 0;
    while ((a_state != 3'd5) && (waited < TMO + 10)) begin
      tick();
      waited++;
    end
    chk_eq("t5_state", a_state, 5);
    chk_eq("t5_window", ((waited >= TMO - 1) && (waited <= TMO + 2)) ? 32'd1 : 32'd0, 1);
    chk_eq("t5_err", a_err, 1);
    chk_eq("t5_eject", a_eject, 1);
    card_in_a = 1'b0; tick();
    chk_eq("t5_idle", a_state, 0);

    // Invalid amount ignored, then card pulled in AMOUNT
    card_in_a = 1'b1; tick();
    pin(1'b1);
    sel(1'b1);
    chk_eq("t6_amount", a_state, 3);
    amt(2'b00);
    chk_eq("t6_invalid_ignored", a_state, 3);
    chk_eq("t6_invalid_noreq", a_req, 0);
    push(1'b1, 16'd20);
    card_in_a = 1'b0; tick();
    chk_eq("t6_idle", a_state, 0);
    chk_eq("t6_err", a_err, 1);
    chk_eq("t6_no_eject", a_eject, 0);

    // Deposit, then reset in the middle of a withdraw
    card_in_a = 1'b1; tick();
    pin(1'b1);
    sel(1'b0);
    push(1'b0, 16'd24);
    amt(2'b11);
    chk_eq("t7_dep_dir", a_dir, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk_eq("t7_dep_bal", a_bal, 24);
    card_in_a = 1'b0; tick();
    card_in_a = 1'b1; tick();
    pin(1'b1);
    sel(1'b1);
    amt(2'b01);
    chk_eq("t7_exec", a_state, 4);
    chk_eq("t7_req", a_req, 1);
    reset = 1'b1; card_in_a = 1'b0; tick();
    chk_eq("t7_rst_req", a_req, 0);
    chk_eq("t7_rst_state", a_state, 0);
    chk_eq("t7_rst_bal", a_bal, 20);
    reset = 1'b0;
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    tick();
    chk_eq("t7_late_ack_state", a_state, 0);
    chk_eq("t7_late_ack_bal", a_bal, 20);
    chk_eq("t7_late_ack_req", a_req, 0);

    tick();
    chk_eq("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/atm_txn_ctrl.md
Name: atm_txn_ctrl

Overview:
- Transaction sequencer for one ATM front-end. Handles card session, PIN retry/lockout, menu, amount selection and balance check.
- Sequences the shared note dispenser/acceptor through a req/ack handshake and keeps the account balance register.
- Sits between the keypad/card-reader decode logic and the cash mechanism controller.

Parameters:
- BAL_W, 16, balance width in note units (1 unit = 50000).
- INIT_BAL, 20, balance loaded at reset (units).
- MAX_TRIES, 3, wrong PINs allowed before card is retained.
- TIMEOUT, 255, idle cycles allowed in PIN/MENU/AMOUNT before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- card_in  in  1  card present in slot
- pin_valid  in  1  one-cycle strobe: PIN entry complete
- pin_ok  in  1  PIN match, sampled with pin_valid
- choice_valid  in  1  one-cycle strobe: menu choice entered
- choice  in  1  0=deposit, 1=withdraw, sampled with choice_valid
- amount_valid  in  1  one-cycle strobe: amount entered
- amount  in  2  01=50000 (1 unit), 10=100000 (2), 11=200000 (4), 00=invalid
- disp_ack  in  1  mechanism finished the requested move
- disp_req  out  1  request to mechanism, held until ack
- disp_dir  out  1  0=accept notes, 1=dispense notes
- disp_amt  out  2  amount code for the mechanism
- balance  out  BAL_W  current balance (units)
- card_eject  out  1  one-cycle eject pulse
- card_retain  out  1  level: card swallowed (lock)
- txn_done  out  1  one-cycle pulse on successful transaction
- txn_err  out  1  one-cycle pulse on refused/aborted transaction
- state_o  out  3  current state, for debug

Behaviour:
- Interface: reset is synchronous, active-high (reset); clock is clock. All outputs are registered.
- Reset values: state IDLE, balance=INIT_BAL, tries=0, timeout count=0. disp_req, disp_dir, disp_amt, card_eject, card_retain, txn_done and txn_err are all 0.
- States, in encoding order: IDLE, PIN, MENU, AMOUNT, EXEC, DONE, LOCK.
- IDLE: card_in=1 -> PIN; clear tries and timeout count.
- PIN, pin_valid with pin_ok=1 -> MENU.
- PIN, pin_valid with pin_ok=0 -> tries+1. If the new tries equals MAX_TRIES -> LOCK; else stay in PIN.
- MENU: choice_valid -> latch choice, go to AMOUNT.
- AMOUNT: amount_valid with amount=00 is ignored (no state change, timeout keeps running).
- AMOUNT, withdraw with units > balance: -> DONE, txn_err pulse, no dispenser request.
- AMOUNT, otherwise: -> EXEC. disp_req=1 in the next cycle, with disp_dir=choice and disp_amt=the latched amount.
- EXEC: disp_req, disp_dir and disp_amt stay stable until the cycle disp_ack=1 is sampled.
- EXEC, on ack: disp_req=0 the next cycle. Balance is updated in the same edge: +units on deposit, saturating at 2^BAL_W-1; -units on withdraw. txn_done pulses, -> DONE.
- EXEC: card_in and the timeout are ignored; the mechanism transfer is never aborted.
- DONE: card_eject pulses on the first DONE cycle. The FSM then waits for card_in=0 -> IDLE.
- LOCK: card_retain=1, txn_err pulses on entry. Stays in LOCK until reset; card_in is ignored.
- Timeout: a counter runs in PIN, MENU and AMOUNT and clears on any accepted strobe and on each state change. When it reaches TIMEOUT -> DONE with txn_err.
- card_in dropping to 0 in PIN, MENU or AMOUNT: -> IDLE next cycle, txn_err pulse, no eject.
- Priority in one cycle: reset > card removal > valid strobe > timeout.
- Strobes that do not belong to the current state are ignored.
- disp_ack outside EXEC is ignored.
- Reset mid-EXEC: disp_req drops immediately and balance returns to INIT_BAL.

Decomposition:
- Package atm_pkg holds:
  - state encoding constants;
  - amount codes FIFTY=01, HUNDRED=10, TWO_HUNDRED=11;
  - DIR_ACCEPT/DIR_DISPENSE;
  - a function mapping amount code -> units (1/2/4).
- Sub-module atm_timeout_cnt (TIMEOUT param; inputs run/clear; output expired) instantiated once.

Test Plan:
- Reset; card_in=1; pin_valid+pin_ok=1; choice=1; amount=10; ack 3 cycles after req -> disp_req held 3 cycles, disp_dir=1, disp_amt=10; balance 20->18; txn_done 1 pulse; card_eject 1 pulse; IDLE after card_in=0.
- Three pin_valid strobes with pin_ok=0 -> LOCK after the third; card_retain=1 and stays 1 with card_in toggling; txn_err 1 pulse.
- Balance=INIT_BAL=3; withdraw amount=11 (4 units) -> no disp_req, txn_err pulse, balance stays 3, card_eject pulse.
- Deposit amount=11 with BAL_W=4, balance=14 -> balance saturates at 15; disp_dir=0.
- In MENU, no input for TIMEOUT cycles -> DONE with txn_err and eject. Separately, card_in=0 in AMOUNT -> IDLE, no eject.
- Reset asserted while in EXEC with disp_req=1 -> next cycle disp_req=0, state IDLE, balance=INIT_BAL; a late disp_ack is ignored.
